// File: rtl/multiply_pkg.sv
// rtl/multiply_pkg.sv - shared constants and controller state encodings for the shift-add multiplier
package multiply_pkg;

    localparam int WIDTH_DEFAULT = 8;
    localparam int CNT_W         = $clog2(WIDTH_DEFAULT + 1);

    // Encodings of the upstream multiply controller, used when sequencing strobes.
    typedef enum logic [1:0] {
        INIT_A = 2'd0,
        INIT_B = 2'd1,
        LOAD   = 2'd2,
        SHIFT  = 2'd3
    } ctrl_state_t;

endpackage

// File: rtl/multiply_adder.sv
// rtl/multiply_adder.sv - WIDTH-bit adder with gated addend and carry out
//
// Ports:
//   augend  in  WIDTH    upper half of the product register
//   addend  in  WIDTH    multiplicand register
//   enable  in  1        when 0 the addend is forced to zero
//   sum     out WIDTH+1  {carry, sum}
module multiply_adder
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] augend,
    input  logic [WIDTH-1:0] addend,
    input  logic             enable,
    output logic [WIDTH:0]   sum
);

    logic [WIDTH-1:0] gated_addend;

    always_comb begin
        gated_addend = enable ? addend : '0;
        sum          = {1'b0, augend} + {1'b0, gated_addend};
    end

endmodule

// File: rtl/multiply_datapath.sv
// rtl/multiply_datapath.sv - shift-add multiplier datapath driven by controller strobes
//
// Ports:
//   clock         in  1        rising-edge clock
//   reset         in  1        asynchronous active-high reset
//   multiplicand  in  WIDTH    operand A, captured on loadA
//   multiplier    in  WIDTH    operand B, captured on loadB with select=0
//   select        in  1        0 = initialise P from multiplier, 1 = accumulate adder output
//   loadA         in  1        load multiplicand register
//   loadB         in  1        load product register
//   shift         in  1        logical right shift of product register
//   lsb           out 1        P[0], sampled by the controller
//   product       out 2*WIDTH  live P[2W-1:0]
//   result        out 2*WIDTH  last completed product
//   result_valid  out 1        one-cycle pulse when result updates
module multiply_datapath
    import multiply_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [WIDTH-1:0]   multiplicand,
    input  logic [WIDTH-1:0]   multiplier,
    input  logic               select,
    input  logic               loadA,
    input  logic               loadB,
    input  logic               shift,
    output logic               lsb,
    output logic [2*WIDTH-1:0] product,
    output logic [2*WIDTH-1:0] result,
    output logic               result_valid
);

    localparam int             PW        = 2 * WIDTH + 1;
    localparam int             CW        = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX   = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);

    logic [WIDTH-1:0]   a_q, a_d;
    logic [PW-1:0]      p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] result_q, result_d;
    logic               result_valid_q, result_valid_d;
    logic [WIDTH:0]     sum;

    // Adder always sees the registered A, so loadA in an accumulate cycle uses the old operand.
    multiply_adder #(.WIDTH(WIDTH)) u_adder (
        .augend (p_q[2*WIDTH-1:WIDTH]),
        .addend (a_q),
        .enable (p_q[0]),
        .sum    (sum)
    );

    always_comb begin
        a_d            = a_q;
        p_d            = p_q;
        cnt_d          = cnt_q;
        result_d       = result_q;
        result_valid_d = 1'b0;

        if (loadA) begin
            a_d = multiplicand;
        end

        // loadB outranks shift; a simultaneous shift is dropped.
        if (loadB && !select) begin
            p_d   = {1'b0, {WIDTH{1'b0}}, multiplier};
            cnt_d = '0;
        end else if (loadB) begin
            p_d = {sum, p_q[WIDTH-1:0]};
        end else if (shift) begin
            p_d = {1'b0, p_q[PW-1:1]};
            // Counter saturates at WIDTH so extra shifts never re-capture.
            if (cnt_q < CNT_MAX) begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CNT_LAST) begin
                    result_d       = p_d[2*WIDTH-1:0];
                    result_valid_d = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            a_q            <= '0;
            p_q            <= '0;
            cnt_q          <= '0;
            result_q       <= '0;
            result_valid_q <= 1'b0;
        end else begin
            a_q            <= a_d;
            p_q            <= p_d;
            cnt_q          <= cnt_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
        end
    end

    assign lsb          = p_q[0];
    assign product      = p_q[2*WIDTH-1:0];
    assign result       = result_q;
    assign result_valid = result_valid_q;

endmodule
